// File: rtl/pw_bit_pkg.sv
// Shared types for the pulse-width bit link.
// Receive FSM states and synchronizer depth.
package pw_bit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK
  } rx_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/pw_bit_rx_sync.sv
// rxd synchronizer and edge detector.
// PW_BIT_RX_GLITCH_FILTER_EN adds a 3-sample majority filter (+2 cycles).
module pw_bit_rx_sync
  import pw_bit_pkg::*;
(
  input  logic aclk,
  input  logic aresetn,
  input  logic rxd,
  output logic rxd_s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_f;
  logic                   rxd_d;

  // two-flop metastability chain
  always_ff @(posedge aclk) begin
    if (!aresetn) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

`ifdef PW_BIT_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  logic       s_new;

  assign s_new = sync_q[SYNC_STAGES-1];

  // majority of three consecutive samples, registered
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], s_new};
      filt_q <= (s_new & hist_q[0]) |
                (s_new & hist_q[1]) |
                (hist_q[0] & hist_q[1]);
    end
  end

  assign rxd_f = filt_q;
`else
  assign rxd_f = sync_q[SYNC_STAGES-1];
`endif

  // one-cycle delayed copy for edge detection
  always_ff @(posedge aclk) begin
    if (!aresetn) rxd_d <= 1'b0;
    else          rxd_d <= rxd_f;
  end

  assign rxd_s = rxd_f;
  assign rise  = rxd_f & ~rxd_d;
  assign fall  = ~rxd_f & rxd_d;

endmodule

// File: rtl/pw_bit_rx_cell.sv
// Pulse-width bit receiver: decodes rxd into AXI-Stream words.
// Optional glitch filter: PW_BIT_RX_GLITCH_FILTER_EN.
module pw_bit_rx_cell
  import pw_bit_pkg::*;
#(
  parameter int COUNTER_WIDTH        = 32,
  parameter int DATA_AXIS_DATA_WIDTH = 8,
  parameter int CFG_AXIS_DATA_WIDTH  = COUNTER_WIDTH
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic                            rxd,
  output logic [DATA_AXIS_DATA_WIDTH-1:0] data_m_axis_tdata,
  output logic                            data_m_axis_tlast,
  output logic                            data_m_axis_tvalid,
  input  logic                            data_m_axis_tready,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  period,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  duty_hi,
  input  logic [CFG_AXIS_DATA_WIDTH-1:0]  duty_lo,
  output logic                            frame_err,
  output logic                            overrun
);

  localparam int CW = COUNTER_WIDTH;
  localparam int DW = DATA_AXIS_DATA_WIDTH;
  localparam int FW = CFG_AXIS_DATA_WIDTH;
  localparam int BW = $clog2(DW + 1);

  rx_state_t state_q, state_d;

  logic          rxd_s, rise, fall;
  logic [CW-1:0] cnt_q;
  logic [FW:0]   thr_q, thr_nxt;
  logic [CW:0]   tmo_q, tmo_nxt;
  logic [CW-1:0] period_ext;
  logic [CW:0]   cnt_ext, thr_ext;
  logic          bit_val, cnt_gt_tmo;

  logic [DW-1:0] shift_q, shift_nxt, pend_q;
  logic          pend_vld_q;
  logic [BW-1:0] bitcnt_q, bitcnt_nxt;
  logic          word_done;

  logic do_latch, do_shift, do_clr;
  logic do_rel, rel_last, err;

  pw_bit_rx_sync u_sync (
    .aclk    (aclk),
    .aresetn (aresetn),
    .rxd     (rxd),
    .rxd_s   (rxd_s),
    .rise    (rise),
    .fall    (fall)
  );

  assign period_ext = CW'(period);
  assign thr_nxt    = ({1'b0, duty_hi} + {1'b0, duty_lo}) >> 1;
  assign tmo_nxt    = {1'b0, period_ext}
                    + {2'b00, period_ext[CW-1:1]};

  assign cnt_ext    = {1'b0, cnt_q};
  assign thr_ext    = (CW+1)'(thr_q);
  assign bit_val    = (cnt_ext >= thr_ext);
  assign cnt_gt_tmo = (cnt_ext > tmo_q);

  assign shift_nxt  = {shift_q[DW-2:0], bit_val};
  assign bitcnt_nxt = bitcnt_q + 1'b1;
  assign word_done  = (bitcnt_nxt == BW'(DW));

  // state register
  always_ff @(posedge aclk) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state and per-cycle actions
  always_comb begin
    state_d  = state_q;
    do_latch = 1'b0;
    do_shift = 1'b0;
    do_clr   = 1'b0;
    do_rel   = 1'b0;
    rel_last = 1'b0;
    err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d  = HIGH;
          do_latch = 1'b1;
          do_rel   = pend_vld_q;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d  = LOW;
          do_shift = 1'b1;
        end else if (cnt_gt_tmo && rxd_s) begin
          state_d = STUCK;
          err     = 1'b1;
          do_clr  = 1'b1;
        end
      end
      LOW: begin
        if (rise) begin
          state_d  = HIGH;
          do_latch = 1'b1;
          do_rel   = pend_vld_q;
        end else if (cnt_gt_tmo) begin
          state_d  = IDLE;
          do_rel   = pend_vld_q;
          rel_last = 1'b1;
          err      = (bitcnt_q != '0);
          do_clr   = 1'b1;
        end
      end
      STUCK: begin
        if (fall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // cycles since last rise, saturating
  always_ff @(posedge aclk) begin
    if (!aresetn)          cnt_q <= '0;
    else if (rise)         cnt_q <= CW'(1);
    else if (cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
  end

  // threshold and timeout captured at each accepted rise
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      thr_q <= '0;
      tmo_q <= '0;
    end else if (do_latch) begin
      thr_q <= thr_nxt;
      tmo_q <= tmo_nxt;
    end
  end

  // bit assembly and pending word
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      shift_q    <= '0;
      bitcnt_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (do_clr) begin
        shift_q  <= '0;
        bitcnt_q <= '0;
      end else if (do_shift) begin
        if (word_done) begin
          pend_q   <= shift_nxt;
          shift_q  <= '0;
          bitcnt_q <= '0;
        end else begin
          shift_q  <= shift_nxt;
          bitcnt_q <= bitcnt_nxt;
        end
      end
      if (do_rel)
        pend_vld_q <= 1'b0;
      else if (do_shift && word_done)
        pend_vld_q <= 1'b1;
    end
  end

  // AXI-Stream output register and sticky overrun
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_m_axis_tdata  <= '0;
      data_m_axis_tlast  <= 1'b0;
      data_m_axis_tvalid <= 1'b0;
      overrun            <= 1'b0;
    end else if (do_rel &&
                 (!data_m_axis_tvalid || data_m_axis_tready)) begin
      data_m_axis_tdata  <= pend_q;
      data_m_axis_tlast  <= rel_last;
      data_m_axis_tvalid <= 1'b1;
    end else begin
      if (do_rel)
        overrun <= 1'b1;
      if (data_m_axis_tvalid && data_m_axis_tready)
        data_m_axis_tvalid <= 1'b0;
    end
  end

  // registered one-cycle error pulse
  always_ff @(posedge aclk) begin
    if (!aresetn) frame_err <= 1'b0;
    else          frame_err <= err;
  end

endmodule

// File: tb/tb_pw_bit_rx_cell.sv
// Self-checking bench for pw_bit_rx_cell.
// Table of single-frame vectors plus hand-written corner sequences.
module tb_pw_bit_rx_cell;

`ifdef PW_BIT_RX_GLITCH_FILTER_EN
  localparam int FD = 2;
`else
  localparam int FD = 0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        rxd = 1'b0;
  logic        tready = 1'b1;
  logic [7:0]  tdata;
  logic        tlast, tvalid;
  logic [31:0] period = 32'd100;
  logic [31:0] duty_hi = 32'd75;
  logic [31:0] duty_lo = 32'd25;
  logic        frame_err, overrun;

  pw_bit_rx_cell dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .rxd                (rxd),
    .data_m_axis_tdata  (tdata),
    .data_m_axis_tlast  (tlast),
    .data_m_axis_tvalid (tvalid),
    .data_m_axis_tready (tready),
    .period             (period),
    .duty_hi            (duty_hi),
    .duty_lo            (duty_lo),
    .frame_err          (frame_err),
    .overrun            (overrun)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nerr = 0;
  int last_err_cyc = 0;
  int last_rise = 0;
  logic [8:0] beats[$];
  int beat_cyc[$];

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (tvalid && tready) begin
      beats.push_back({tlast, tdata});
      beat_cyc.push_back(cyc);
    end
    if (frame_err) begin
      nerr++;
      last_err_cyc = cyc;
    end
  end

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          nbeats;
    logic [7:0]  d0;
    logic [7:0]  d1;
    int          nerr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic v, int n);
    rxd = v;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_bit(logic b);
    last_rise = cyc;
    drive(1'b1, b ? 75 : 25);
    drive(1'b0, b ? 25 : 75);
  endtask

  task automatic send_frame(logic [15:0] bits, int n);
    for (int i = 0; i < n; i++) send_bit(bits[15-i]);
  endtask

  task automatic do_reset(int n);
    aresetn = 1'b0;
    rxd = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic chk_frame(string nm, int bb, int eb, int n,
                           logic [7:0] d0, logic [7:0] d1, int ne);
    int got;
    got = beats.size() - bb;
    chk({nm, " beats"}, got, n);
    chk({nm, " errs"}, nerr - eb, ne);
    for (int k = 0; k < n; k++) begin
      if (k < got) begin
        chk({nm, " tdata"}, beats[bb+k][7:0], k == 0 ? d0 : d1);
        chk({nm, " tlast"}, beats[bb+k][8], k == n - 1);
      end
    end
  endtask

  initial begin
    int bb, eb;

    vecs[0] = '{16'hCC00, 8, 1, 8'hCC, 8'h00, 0};
    vecs[1] = '{16'hA53C, 16, 2, 8'hA5, 8'h3C, 0};
    vecs[2] = '{16'hFF00, 8, 1, 8'hFF, 8'h00, 0};
    vecs[3] = '{16'h0000, 8, 1, 8'h00, 8'h00, 0};
    vecs[4] = '{16'hB000, 5, 0, 8'h00, 8'h00, 1};
    vecs[5] = '{16'h8100, 8, 1, 8'h81, 8'h00, 0};

    do_reset(3);
    chk("rst tvalid", tvalid, 0);
    chk("rst tdata", tdata, 0);
    chk("rst tlast", tlast, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst overrun", overrun, 0);
    aresetn = 1'b1;
    drive(1'b0, 10);

    for (int i = 0; i < 6; i++) begin
      bb = beats.size();
      eb = nerr;
      send_frame(vecs[i].bits, vecs[i].nbits);
      drive(1'b0, 200);
      chk_frame($sformatf("vec%0d", i), bb, eb, vecs[i].nbeats,
                vecs[i].d0, vecs[i].d1, vecs[i].nerr);
      if (i == 0 && beats.size() > bb)
        chk("vec0 latency", beat_cyc[bb] - last_rise, 154 + FD);
    end
    chk("no overrun", overrun, 0);

    // output held while downstream stalls
    tready = 1'b0;
    bb = beats.size();
    send_frame(16'h1122, 16);
    send_frame(16'h3300, 8);
    drive(1'b0, 200);
    chk("stall tvalid", tvalid, 1);
    chk("stall tdata", tdata, 8'h11);
    chk("stall tlast", tlast, 0);
    chk("stall overrun", overrun, 1);
    chk("stall beats", beats.size() - bb, 0);
    tready = 1'b1;
    drive(1'b0, 3);
    chk("drain beats", beats.size() - bb, 1);
    if (beats.size() > bb)
      chk("drain tdata", beats[bb][7:0], 8'h11);
    chk("drain tvalid", tvalid, 0);
    chk("overrun sticky", overrun, 1);
    do_reset(2);
    chk("overrun cleared", overrun, 0);
    aresetn = 1'b1;
    drive(1'b0, 10);

    // line stuck high
    bb = beats.size();
    eb = nerr;
    last_rise = cyc;
    drive(1'b1, 300);
    drive(1'b0, 50);
    chk("stuck errs", nerr - eb, 1);
    chk("stuck err time", last_err_cyc - last_rise, 154 + FD);
    chk("stuck beats", beats.size() - bb, 0);
    bb = beats.size();
    eb = nerr;
    send_frame(16'h0F00, 8);
    drive(1'b0, 200);
    chk_frame("after stuck", bb, eb, 1, 8'h0F, 8'h00, 0);

    // reset mid-word
    send_frame(16'hE000, 3);
    drive(1'b1, 30);
    do_reset(2);
    chk("midrst tvalid", tvalid, 0);
    chk("midrst tdata", tdata, 0);
    chk("midrst frame_err", frame_err, 0);
    aresetn = 1'b1;
    bb = beats.size();
    eb = nerr;
    drive(1'b0, 200);
    chk("midrst quiet beats", beats.size() - bb, 0);
    chk("midrst quiet errs", nerr - eb, 0);
    send_frame(16'h5A00, 8);
    drive(1'b0, 200);
    chk_frame("after rst", bb, eb, 1, 8'h5A, 8'h00, 0);

    // zero period: every bit times out
    period = 32'd0;
    bb = beats.size();
    eb = nerr;
    send_frame(16'hC000, 2);
    drive(1'b0, 200);
    chk("p0 errs", nerr - eb, 2);
    chk("p0 beats", beats.size() - bb, 0);
    period = 32'd100;

`ifdef PW_BIT_RX_GLITCH_FILTER_EN
    bb = beats.size();
    eb = nerr;
    send_frame(16'hF000, 3);
    drive(1'b1, 30);
    drive(1'b0, 1);
    drive(1'b1, 44);
    drive(1'b0, 25);
    send_frame(16'hF000, 4);
    drive(1'b0, 200);
    chk_frame("glitch", bb, eb, 1, 8'hFF, 8'h00, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
